exec_unit_mul: RTL and testbench
================================

# exec_unit_mul

Parametrised, registered integer execution unit for the out-of-order core; successor to the single-cycle combinational ALU. It accepts one op per cycle from the RS under a valid/ready handshake and registers every result. It adds an iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) and flush on mispredict. Results go on the shared CDB to RS, LSB and ROB.

## Interface
- XLEN, 32: data/address width; multiple of MUL_STEP.
- ROB_W, 4: ROB tag width; tag 0 is reserved and means "no result".
- OP_W, 6: width of the shared OPENUM op encoding, which includes OPENUM_MUL/MULH/MULHSU/MULHU.
- MUL_STEP, 4: multiplier bits retired per iteration; N = XLEN/MUL_STEP iterations.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global clock enable; when 0 every register holds and in_ready=0.
- flush  in  1  mispredict clear; synchronous, qualified by rdy.
- in_valid  in  1  op offered by the RS.
- in_ready  out  1  unit can accept; equals (state==IDLE).
- in_op  in  OP_W  operation.
- in_value1, in_value2, in_imm  in  XLEN  operands.
- in_pc  in  XLEN  instruction PC.
- in_rob_tag  in  ROB_W  destination ROB entry.
- out_valid  out  1  result valid for one cycle.
- out_rob_tag  out  ROB_W  result tag; 0 whenever out_valid=0.
- out_value  out  XLEN  result / branch decision (1 = taken, 0 = not taken).
- out_newpc  out  XLEN  target for JALR and branches, else 0.

## Operation
- Accept = rdy & in_valid & in_ready & ~flush & (in_rob_tag!=0). An offer with tag 0 is dropped. OPENUM_NOP is accepted and produces no output.
- Simple ops compute the same results as the existing ALU (LUI, AUIPC, JAL, JALR, BEQ..BGEU, OP-IMM, OP), with these changes:
  - Shift amount is the low log2(XLEN) bits of value2/imm.
  - SRA/SRAI are signed arithmetic shifts.
  - JALR newpc = (value1+imm) & ~1.
  - Branch newpc = pc+imm.
  - All arithmetic wraps modulo 2^XLEN.
- Simple op results load the output register at the accept edge.
- States: IDLE, MUL_ITER, MUL_FIN.
  - IDLE -> MUL_ITER on accepting a MUL-class op. The accept edge latches operand magnitudes, the result sign (MUL/MULH: s1^s2; MULHSU: s1; MULHU: 0), the op and the tag. The 2·XLEN accumulator and the iteration counter are cleared.
  - MUL_ITER: each edge adds magnitude1 × (next MUL_STEP bits of magnitude2) << (i·MUL_STEP) into the accumulator. After N edges -> MUL_FIN.
  - MUL_FIN: one edge applies the sign (two's-complement negate of the 2·XLEN product), selects the low half for MUL or the high half otherwise, loads the output register, and goes -> IDLE.
- flush (rdy=1):
  - Clears out_valid/out_rob_tag at the next edge.
  - Aborts MUL_ITER/MUL_FIN -> IDLE.
  - Drops any same-cycle offer.
  - flush has priority over every other event.
- Reset (asynchronous, any state): state=IDLE, out_valid=0, out_rob_tag=0, out_value=0, out_newpc=0, accumulator and counter=0. in_ready becomes 1 once rst deasserts and rdy=1.

## Timing
- Accept at edge E, simple op: out_valid=1 for exactly the cycle after E. Back-to-back accepts give one result per cycle.
- Accept at edge E, MUL-class op:
  - in_ready=0 from E until edge E+N+1.
  - out_valid=1 in the cycle after E+N+1, so latency is N+1 cycles (9 with defaults).
  - in_ready=1 again in that same cycle, so a new op can be accepted in parallel with the MUL result.
- The output register is rewritten every enabled edge: out_valid falls after one cycle unless a new result loads.
- rdy=0 at any point: state, counter, accumulator and outputs freeze. The cycle count resumes when rdy returns.
- The output has no backpressure; CDB consumers must take the result in the cycle out_valid=1.

## Test plan
- Simple ops:
  - ADD 0xFFFFFFFF+1, tag 3 -> next cycle out_valid=1, out_value=0, tag 3.
  - SRA 0x80000000 by 33 -> out_value=0xC0000000.
- Branches:
  - BLT value1=-1, value2=1, pc=0x100, imm=-8 -> out_value=1, newpc=0xF8.
  - BLTU with the same operands -> out_value=0.
- JALR value1=0x1001, imm=2, pc=0x40 -> out_value=0x44, newpc=0x1002.
- Multiplier:
  - MULH -1×-1 -> in_ready=0 for 9 cycles, then out_value=0.
  - MUL 0x10000×0x10000 -> out_value=0.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> out_value=0xFFFFFFFE.
  - ADD offered in the result cycle -> accepted, its result appears the next cycle.
- Flush and stall:
  - flush at iteration 4 of MUL -> no result, in_ready=1 next cycle.
  - flush together with in_valid -> offer dropped.
  - rdy=0 for 3 cycles mid-MUL -> result arrives exactly 3 cycles later.
- Reset and tags:
  - rst low mid-MUL -> all outputs 0 immediately, IDLE after release.
  - in_valid with tag 0 -> no output.

Source files
------------

// File: rtl/exec_unit_mul.sv
// rtl/exec_unit_mul.sv - registered integer execution unit with iterative RV32M multiplier
module exec_unit_mul #(
   parameter int XLEN     = 32,
   parameter int ROB_W    = 4,
   parameter int OP_W     = 6,
   parameter int MUL_STEP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [XLEN-1:0]  in_value1,
   input  logic [XLEN-1:0]  in_value2,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [ROB_W-1:0] in_rob_tag,
   output logic             out_valid,
   output logic [ROB_W-1:0] out_rob_tag,
   output logic [XLEN-1:0]  out_value,
   output logic [XLEN-1:0]  out_newpc
);

   // shared op encoding
   localparam logic [OP_W-1:0] OP_NOP    = OP_W'(0);
   localparam logic [OP_W-1:0] OP_LUI    = OP_W'(1);
   localparam logic [OP_W-1:0] OP_AUIPC  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_JAL    = OP_W'(3);
   localparam logic [OP_W-1:0] OP_JALR   = OP_W'(4);
   localparam logic [OP_W-1:0] OP_BEQ    = OP_W'(5);
   localparam logic [OP_W-1:0] OP_BNE    = OP_W'(6);
   localparam logic [OP_W-1:0] OP_BLT    = OP_W'(7);
   localparam logic [OP_W-1:0] OP_BGE    = OP_W'(8);
   localparam logic [OP_W-1:0] OP_BLTU   = OP_W'(9);
   localparam logic [OP_W-1:0] OP_BGEU   = OP_W'(10);
   localparam logic [OP_W-1:0] OP_ADDI   = OP_W'(11);
   localparam logic [OP_W-1:0] OP_SLTI   = OP_W'(12);
   localparam logic [OP_W-1:0] OP_SLTIU  = OP_W'(13);
   localparam logic [OP_W-1:0] OP_XORI   = OP_W'(14);
   localparam logic [OP_W-1:0] OP_ORI    = OP_W'(15);
   localparam logic [OP_W-1:0] OP_ANDI   = OP_W'(16);
   localparam logic [OP_W-1:0] OP_SLLI   = OP_W'(17);
   localparam logic [OP_W-1:0] OP_SRLI   = OP_W'(18);
   localparam logic [OP_W-1:0] OP_SRAI   = OP_W'(19);
   localparam logic [OP_W-1:0] OP_ADD    = OP_W'(20);
   localparam logic [OP_W-1:0] OP_SUB    = OP_W'(21);
   localparam logic [OP_W-1:0] OP_SLL    = OP_W'(22);
   localparam logic [OP_W-1:0] OP_SLT    = OP_W'(23);
   localparam logic [OP_W-1:0] OP_SLTU   = OP_W'(24);
   localparam logic [OP_W-1:0] OP_XOR    = OP_W'(25);
   localparam logic [OP_W-1:0] OP_SRL    = OP_W'(26);
   localparam logic [OP_W-1:0] OP_SRA    = OP_W'(27);
   localparam logic [OP_W-1:0] OP_OR     = OP_W'(28);
   localparam logic [OP_W-1:0] OP_AND    = OP_W'(29);
   localparam logic [OP_W-1:0] OP_MUL    = OP_W'(30);
   localparam logic [OP_W-1:0] OP_MULH   = OP_W'(31);
   localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(32);
   localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(33);

   localparam int N     = XLEN / MUL_STEP;
   localparam int SH_W  = $clog2(XLEN);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL_ITER, S_MUL_FIN} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [XLEN-1:0]      r_mag1;
   logic [XLEN-1:0]      r_mag2;
   logic [2*XLEN-1:0]    r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_neg;
   logic                 r_mul_low;
   logic [ROB_W-1:0]     r_mul_tag;
   logic                 r_out_valid;
   logic [ROB_W-1:0]     r_out_tag;
   logic [XLEN-1:0]      r_out_value;
   logic [XLEN-1:0]      r_out_newpc;

   logic                 w_in_ready;
   logic                 w_accept;
   logic                 w_is_mul;
   logic                 w_s1;
   logic                 w_s2;
   logic                 w_last;
   logic [XLEN+MUL_STEP-1:0] w_part;
   logic [2*XLEN-1:0]    w_pp;
   logic [2*XLEN-1:0]    w_prod;
   logic [XLEN-1:0]      w_mul_res;
   logic                 w_has;
   logic [XLEN-1:0]      w_val;
   logic [XLEN-1:0]      w_npc;
   logic [SH_W-1:0]      w_sh2;
   logic [SH_W-1:0]      w_shi;
   logic [XLEN-1:0]      w_pc_imm;

   assign w_is_mul   = (in_op == OP_MUL) | (in_op == OP_MULH) |
                       (in_op == OP_MULHSU) | (in_op == OP_MULHU);
   assign w_in_ready = rst & rdy & (r_state == S_IDLE);
   assign w_accept   = rdy & in_valid & w_in_ready & ~flush & (in_rob_tag != '0);
   assign w_s1       = in_value1[XLEN-1] & (in_op != OP_MULHU);
   assign w_s2       = in_value2[XLEN-1] & ((in_op == OP_MUL) | (in_op == OP_MULH));
   assign w_last     = (r_cnt == CNT_W'(N - 1));
   assign w_sh2      = in_value2[SH_W-1:0];
   assign w_shi      = in_imm[SH_W-1:0];
   assign w_pc_imm   = in_pc + in_imm;

   // one multiplier slice per iteration, placed at its digit position
   assign w_part    = {{MUL_STEP{1'b0}}, r_mag1} * {{XLEN{1'b0}}, r_mag2[MUL_STEP-1:0]};
   assign w_pp      = {{(XLEN-MUL_STEP){1'b0}}, w_part} << (r_cnt * MUL_STEP);
   assign w_prod    = r_neg ? (~r_acc + 1'b1) : r_acc;
   assign w_mul_res = r_mul_low ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

   assign in_ready    = w_in_ready;
   assign out_valid   = r_out_valid;
   assign out_rob_tag = r_out_tag;
   assign out_value   = r_out_value;
   assign out_newpc   = r_out_newpc;

   // single-cycle ALU result for the op currently offered
   always_comb begin
      w_has = 1'b1;
      w_val = '0;
      w_npc = '0;
      case (in_op)
         OP_LUI:   w_val = in_imm;
         OP_AUIPC: w_val = w_pc_imm;
         OP_JAL:   w_val = in_pc + XLEN'(4);
         OP_JALR: begin
            w_val = in_pc + XLEN'(4);
            w_npc = (in_value1 + in_imm) & ~XLEN'(1);
         end
         OP_BEQ:  begin w_val = XLEN'(in_value1 == in_value2); w_npc = w_pc_imm; end
         OP_BNE:  begin w_val = XLEN'(in_value1 != in_value2); w_npc = w_pc_imm; end
         OP_BLT:  begin w_val = XLEN'($signed(in_value1) < $signed(in_value2)); w_npc = w_pc_imm; end
         OP_BGE:  begin w_val = XLEN'($signed(in_value1) >= $signed(in_value2)); w_npc = w_pc_imm; end
         OP_BLTU: begin w_val = XLEN'(in_value1 < in_value2); w_npc = w_pc_imm; end
         OP_BGEU: begin w_val = XLEN'(in_value1 >= in_value2); w_npc = w_pc_imm; end
         OP_ADDI:  w_val = in_value1 + in_imm;
         OP_SLTI:  w_val = XLEN'($signed(in_value1) < $signed(in_imm));
         OP_SLTIU: w_val = XLEN'(in_value1 < in_imm);
         OP_XORI:  w_val = in_value1 ^ in_imm;
         OP_ORI:   w_val = in_value1 | in_imm;
         OP_ANDI:  w_val = in_value1 & in_imm;
         OP_SLLI:  w_val = in_value1 << w_shi;
         OP_SRLI:  w_val = in_value1 >> w_shi;
         OP_SRAI:  w_val = $signed(in_value1) >>> w_shi;
         OP_ADD:   w_val = in_value1 + in_value2;
         OP_SUB:   w_val = in_value1 - in_value2;
         OP_SLL:   w_val = in_value1 << w_sh2;
         OP_SLT:   w_val = XLEN'($signed(in_value1) < $signed(in_value2));
         OP_SLTU:  w_val = XLEN'(in_value1 < in_value2);
         OP_XOR:   w_val = in_value1 ^ in_value2;
         OP_SRL:   w_val = in_value1 >> w_sh2;
         OP_SRA:   w_val = $signed(in_value1) >>> w_sh2;
         OP_OR:    w_val = in_value1 | in_value2;
         OP_AND:   w_val = in_value1 & in_value2;
         default:  w_has = 1'b0;
      endcase
   end

   // state register, frozen while rdy is low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else if (rdy) begin
         r_state <= w_next;
      end
   end

   // next-state: flush aborts any multiply in flight
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (w_accept && w_is_mul) w_next = S_MUL_ITER;
         S_MUL_ITER: if (w_last) w_next = S_MUL_FIN;
         S_MUL_FIN:  w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
      if (flush) w_next = S_IDLE;
   end

   // multiplier datapath and output register; outputs clear every enabled edge unless loaded
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mag1      <= '0;
         r_mag2      <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_neg       <= 1'b0;
         r_mul_low   <= 1'b0;
         r_mul_tag   <= '0;
         r_out_valid <= 1'b0;
         r_out_tag   <= '0;
         r_out_value <= '0;
         r_out_newpc <= '0;
      end else if (rdy) begin
         r_out_valid <= 1'b0;
         r_out_tag   <= '0;
         r_out_value <= '0;
         r_out_newpc <= '0;
         if (!flush) begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept && w_is_mul) begin
                     r_mag1    <= w_s1 ? (~in_value1 + 1'b1) : in_value1;
                     r_mag2    <= w_s2 ? (~in_value2 + 1'b1) : in_value2;
                     r_neg     <= w_s1 ^ w_s2;
                     r_mul_low <= (in_op == OP_MUL);
                     r_mul_tag <= in_rob_tag;
                     r_acc     <= '0;
                     r_cnt     <= '0;
                  end else if (w_accept && w_has) begin
                     r_out_valid <= 1'b1;
                     r_out_tag   <= in_rob_tag;
                     r_out_value <= w_val;
                     r_out_newpc <= w_npc;
                  end
               end
               S_MUL_ITER: begin
                  r_acc  <= r_acc + w_pp;
                  r_mag2 <= r_mag2 >> MUL_STEP;
                  r_cnt  <= r_cnt + 1'b1;
               end
               S_MUL_FIN: begin
                  r_out_valid <= 1'b1;
                  r_out_tag   <= r_mul_tag;
                  r_out_value <= w_mul_res;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_exec_unit_mul.sv
// tb/tb_exec_unit_mul.sv - self-checking bench for exec_unit_mul
module tb_exec_unit_mul;

   localparam int N = 8;

   localparam logic [5:0] NOP = 0, LUI = 1, AUIPC = 2, JAL = 3, JALR = 4, BEQ = 5,
      BNE = 6, BLT = 7, BGE = 8, BLTU = 9, BGEU = 10, ADDI = 11, SLTI = 12,
      SLTIU = 13, XORI = 14, ORI = 15, ANDI = 16, SLLI = 17, SRLI = 18, SRAI = 19,
      ADD = 20, SUB = 21, SLL = 22, SLT = 23, SLTU = 24, XOR_ = 25, SRL = 26,
      SRA = 27, OR_ = 28, AND_ = 29, MUL = 30, MULH = 31, MULHSU = 32, MULHU = 33;

   logic        clk, rst, rdy, flush, in_valid, in_ready;
   logic [5:0]  in_op;
   logic [31:0] in_value1, in_value2, in_imm, in_pc;
   logic [3:0]  in_rob_tag;
   logic        out_valid;
   logic [3:0]  out_rob_tag;
   logic [31:0] out_value, out_newpc;

   exec_unit_mul dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_value1(in_value1), .in_value2(in_value2), .in_imm(in_imm), .in_pc(in_pc),
      .in_rob_tag(in_rob_tag), .out_valid(out_valid), .out_rob_tag(out_rob_tag),
      .out_value(out_value), .out_newpc(out_newpc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic        has;
      logic        mul;
      logic [31:0] val;
      logic [31:0] npc;
   } res_t;

   // architectural result of one op, straight from the instruction semantics
   function automatic res_t model(input logic [5:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] imm,
                                  input logic [31:0] pc);
      res_t r;
      logic signed [63:0] x, y, p;
      r = '0;
      r.has = 1'b1;
      case (op)
         LUI:   r.val = imm;
         AUIPC: r.val = pc + imm;
         JAL:   r.val = pc + 4;
         JALR:  begin r.val = pc + 4; r.npc = (a + imm) & 32'hFFFF_FFFE; end
         BEQ:   begin r.val = {31'd0, a == b}; r.npc = pc + imm; end
         BNE:   begin r.val = {31'd0, a != b}; r.npc = pc + imm; end
         BLT:   begin r.val = {31'd0, $signed(a) < $signed(b)}; r.npc = pc + imm; end
         BGE:   begin r.val = {31'd0, $signed(a) >= $signed(b)}; r.npc = pc + imm; end
         BLTU:  begin r.val = {31'd0, a < b}; r.npc = pc + imm; end
         BGEU:  begin r.val = {31'd0, a >= b}; r.npc = pc + imm; end
         ADDI:  r.val = a + imm;
         SLTI:  r.val = {31'd0, $signed(a) < $signed(imm)};
         SLTIU: r.val = {31'd0, a < imm};
         XORI:  r.val = a ^ imm;
         ORI:   r.val = a | imm;
         ANDI:  r.val = a & imm;
         SLLI:  r.val = a << (imm % 32);
         SRLI:  r.val = a >> (imm % 32);
         SRAI:  r.val = $signed(a) >>> (imm % 32);
         ADD:   r.val = a + b;
         SUB:   r.val = a - b;
         SLL:   r.val = a << (b % 32);
         SLT:   r.val = {31'd0, $signed(a) < $signed(b)};
         SLTU:  r.val = {31'd0, a < b};
         XOR_:  r.val = a ^ b;
         SRL:   r.val = a >> (b % 32);
         SRA:   r.val = $signed(a) >>> (b % 32);
         OR_:   r.val = a | b;
         AND_:  r.val = a & b;
         MUL, MULH, MULHSU, MULHU: begin
            r.mul = 1'b1;
            x = (op == MULHU) ? {32'd0, a} : {{32{a[31]}}, a};
            y = (op == MUL || op == MULH) ? {{32{b[31]}}, b} : {32'd0, b};
            p = x * y;
            r.val = (op == MUL) ? p[31:0] : p[63:32];
         end
         default: r.has = 1'b0;
      endcase
      return r;
   endfunction

   res_t        m_now;
   res_t        m_pres;
   logic        m_valid = 1'b0;
   logic [3:0]  m_tag   = '0;
   logic [31:0] m_val   = '0;
   logic [31:0] m_npc   = '0;
   logic        m_pend  = 1'b0;
   int          m_cnt   = 0;
   logic [3:0]  m_ptag  = '0;

   assign m_now = model(in_op, in_value1, in_value2, in_imm, in_pc);

   // cycle-level expectation: a multiply occupies the unit for N+1 enabled edges
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid <= 1'b0; m_tag <= '0; m_val <= '0; m_npc <= '0;
         m_pend  <= 1'b0; m_cnt <= 0;
      end else if (rdy) begin
         m_valid <= 1'b0; m_tag <= '0; m_val <= '0; m_npc <= '0;
         if (flush) begin
            m_pend <= 1'b0;
         end else if (m_pend) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_pend  <= 1'b0;
               m_valid <= 1'b1;
               m_tag   <= m_ptag;
               m_val   <= m_pres.val;
            end
         end else if (in_valid && in_rob_tag != 0) begin
            if (m_now.mul) begin
               m_pend <= 1'b1; m_cnt <= N + 1; m_pres <= m_now; m_ptag <= in_rob_tag;
            end else if (m_now.has) begin
               m_valid <= 1'b1; m_tag <= in_rob_tag; m_val <= m_now.val; m_npc <= m_now.npc;
            end
         end
      end
   end

   // compare process, away from the active edge
   always @(negedge clk) begin
      chk("m_in_ready", in_ready, {31'd0, rst && rdy && !m_pend});
      chk("m_out_valid", out_valid, m_valid);
      chk("m_out_tag", out_rob_tag, m_tag);
      if (m_valid) begin
         chk("m_out_value", out_value, m_val);
         chk("m_out_newpc", out_newpc, m_npc);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
      in_op = op; in_value1 = a; in_value2 = b; in_imm = imm; in_pc = pc;
      in_rob_tag = tag; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_res(output int cyc, output int busy);
      cyc = 0;
      busy = 0;
      while (!out_valid && cyc < 40) begin
         if (!in_ready) busy++;
         step();
         cyc++;
      end
      if (!out_valid) chk("result_timeout", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic count_valid(input int n, output int v);
      v = 0;
      for (int k = 0; k < n; k++) begin
         if (out_valid) v++;
         step();
      end
   endtask

   int cyc, busy, nv;
   logic [31:0] ta[4] = '{32'h0000_0005, 32'hFFFF_FFF0, 32'h8000_0001, 32'h1234_5678};
   logic [31:0] tb[4] = '{32'h0000_0003, 32'h0000_0024, 32'hFFFF_FFFF, 32'h8765_4321};

   initial begin
      rst = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
      in_value1 = '0; in_value2 = '0; in_imm = '0; in_pc = '0; in_rob_tag = '0;
      step(); step();
      chk("rst_valid", {31'd0, out_valid}, 0);
      chk("rst_tag", {28'd0, out_rob_tag}, 0);
      chk("rst_value", out_value, 0);
      chk("rst_newpc", out_newpc, 0);
      chk("rst_ready", {31'd0, in_ready}, 0);
      rst = 1'b1;
      step();
      chk("idle_ready", {31'd0, in_ready}, 1);

      drive(ADD, 32'hFFFF_FFFF, 32'd1, 0, 0, 4'd3);
      chk("add_valid", {31'd0, out_valid}, 1);
      chk("add_value", out_value, 0);
      chk("add_tag", {28'd0, out_rob_tag}, 3);
      drive(SRA, 32'h8000_0000, 32'd33, 0, 0, 4'd4);
      chk("sra_value", out_value, 32'hC000_0000);
      drive(BLT, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 4'd5);
      chk("blt_value", out_value, 1);
      chk("blt_newpc", out_newpc, 32'hF8);
      drive(BLTU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 4'd6);
      chk("bltu_value", out_value, 0);
      drive(JALR, 32'h1001, 0, 32'd2, 32'h40, 4'd7);
      chk("jalr_value", out_value, 32'h44);
      chk("jalr_newpc", out_newpc, 32'h1002);
      step();
      chk("valid_falls", {31'd0, out_valid}, 0);

      for (int s = 0; s < 4; s++)
         for (int op = 1; op <= 29; op++)
            drive(6'(op), ta[s], tb[s], tb[s] ^ 32'h0000_0F0F, ta[s] + 32'h1000, 4'(1 + (op % 15)));
      step();

      drive(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'd9);
      wait_res(cyc, busy);
      chk("mulh_busy", busy, 9);
      chk("mulh_latency", cyc, 9);
      chk("mulh_value", out_value, 0);
      chk("mulh_tag", {28'd0, out_rob_tag}, 9);
      chk("ready_in_result", {31'd0, in_ready}, 1);
      drive(ADD, 32'd2, 32'd3, 0, 0, 4'd7);
      chk("add_after_mul", out_value, 5);
      chk("add_after_mul_tag", {28'd0, out_rob_tag}, 7);

      drive(MUL, 32'h1_0000, 32'h1_0000, 0, 0, 4'd2);
      wait_res(cyc, busy);
      chk("mul_wrap", out_value, 0);
      drive(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 4'd3);
      wait_res(cyc, busy);
      chk("mulhu_value", out_value, 32'hFFFF_FFFE);
      drive(MUL, 32'd7, 32'hFFFF_FFFD, 0, 0, 4'd4);
      wait_res(cyc, busy);
      chk("mul_neg", out_value, 32'hFFFF_FFEB);
      drive(MULHSU, 32'hFFFF_FFFE, 32'd3, 0, 0, 4'd5);
      wait_res(cyc, busy);
      chk("mulhsu_value", out_value, 32'hFFFF_FFFF);
      drive(MULH, 32'h8000_0000, 32'h8000_0000, 0, 0, 4'd6);
      wait_res(cyc, busy);
      chk("mulh_minneg", out_value, 32'h4000_0000);
      step();

      drive(MUL, 32'd5, 32'd6, 0, 0, 4'd8);
      step(); step(); step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_ready", {31'd0, in_ready}, 1);
      chk("flush_novalid", {31'd0, out_valid}, 0);
      count_valid(12, nv);
      chk("flush_no_result", nv, 0);

      flush = 1'b1;
      drive(ADD, 32'd1, 32'd1, 0, 0, 4'd5);
      flush = 1'b0;
      chk("flush_drop", {31'd0, out_valid}, 0);

      drive(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 4'd10);
      step(); step();
      rdy = 1'b0;
      step(); step(); step();
      rdy = 1'b1;
      wait_res(cyc, busy);
      chk("stall_latency", 5 + cyc, 12);
      chk("stall_value", out_value, 32'h0B00_EA4E);
      step();

      drive(ADD, 32'd5, 32'd6, 0, 0, 4'd2);
      rst = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 0);
      chk("arst_value", out_value, 0);
      chk("arst_tag", {28'd0, out_rob_tag}, 0);
      step();
      rst = 1'b1;
      step();
      drive(MUL, 32'd9, 32'd9, 0, 0, 4'd6);
      step(); step(); step();
      rst = 1'b0;
      #1;
      chk("arst_mul_ready", {31'd0, in_ready}, 0);
      step();
      rst = 1'b1;
      step();
      chk("arst_idle", {31'd0, in_ready}, 1);
      count_valid(12, nv);
      chk("arst_no_result", nv, 0);

      drive(ADD, 32'd1, 32'd2, 0, 0, 4'd0);
      chk("tag0_drop", {31'd0, out_valid}, 0);
      drive(NOP, 32'd1, 32'd2, 0, 0, 4'd4);
      chk("nop_silent", {31'd0, out_valid}, 0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
